// File: rtl/data_mem_p_if.sv
// Load/store bus between the execute stage and the data memory.
// The master issues write/read requests; the slave returns registered
// read data and the status flags.
interface data_mem_p_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int NB = DATA_W / 8;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [NB-1:0]     wr_be;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic              acc_drop;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        input  rd_data, rd_valid, busy, acc_drop
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
        output rd_data, rd_valid, busy, acc_drop
    );
endinterface

// File: rtl/data_mem_p.sv
// Parametrised data memory: DEPTH x DATA_W array with one byte-enabled
// write port and one registered read port. After reset the array is
// swept with a fill pattern; requests arriving during the sweep are
// dropped and flagged.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_INIT  | fill sweep running, busy=1, requests dropped (acc_drop set)
//  ST_READY | normal operation, writes and reads accepted
module data_mem_p #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int INIT_MODE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    data_mem_p_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;
    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    typedef enum logic {ST_INIT, ST_READY} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_word;

    // Replace the bytes selected by be with the new word, keep the rest.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NB-1:0]     be
    );
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int k = 0; k < NB; k++) begin
            if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
        end
        return r;
    endfunction

    // Fill value for location a; the cast zero-extends or truncates.
    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
        if (INIT_MODE == 1) return DATA_W'(a);
        return '0;
    endfunction

    // Select the array write source: sweep pattern in INIT, merged user write in READY.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cnt;
        mem_wdata = pattern(cnt);
        if (rst_n) begin
            if (state == ST_INIT) begin
                mem_we = 1'b1;
            end else if (bus.wr_en) begin
                mem_we    = 1'b1;
                mem_waddr = bus.wr_addr;
                mem_wdata = merge_bytes(mem[bus.wr_addr], bus.wr_data, bus.wr_be);
            end
        end
    end

    // Read word with write-first forwarding when both ports hit one address.
    always_comb begin
        rd_word = mem[bus.rd_addr];
        if (bus.wr_en && (bus.wr_addr == bus.rd_addr)) begin
            rd_word = merge_bytes(mem[bus.rd_addr], bus.wr_data, bus.wr_be);
        end
    end

    // Array storage; contents are never touched by reset itself.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Control FSM with registered read port and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_INIT;
            cnt          <= '0;
            bus.busy     <= 1'b1;
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
            bus.acc_drop <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    cnt          <= cnt + 1'b1;
                    bus.rd_valid <= 1'b0;
                    if (bus.wr_en || bus.rd_en) bus.acc_drop <= 1'b1;
                    if (cnt == CNT_LAST) begin
                        state    <= ST_READY;
                        bus.busy <= 1'b0;
                    end
                end
                ST_READY: begin
                    bus.rd_valid <= bus.rd_en;
                    if (bus.rd_en) bus.rd_data <= rd_word;
                end
                default: begin
                    state    <= ST_INIT;
                    cnt      <= '0;
                    bus.busy <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_p.sv
// Scoreboard bench for data_mem_p (DATA_W=32, ADDR_W=5, INIT_MODE=1).
// Reads push their expected word; a negedge monitor pops on rd_valid.
module tb_data_mem_p;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    data_mem_p_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    data_mem_p #(.DATA_W(32), .ADDR_W(5), .INIT_MODE(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every presented read result is checked against the queue head.
    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rd_valid", 32'd1, 32'd0);
            end else begin
                check("rd_data", bus.rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.wr_be   = '0;
        bus.rd_en   = 1'b0;
        bus.rd_addr = '0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp);
        exp_q.push_back(exp);
        bus.rd_en   = 1'b1;
        bus.rd_addr = a;
        tick();
        bus.rd_en   = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        bus.wr_be   = be;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic wr_rd(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be,
                         input logic [4:0] ra, input logic [31:0] exp);
        exp_q.push_back(exp);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        bus.wr_be   = be;
        bus.rd_en   = 1'b1;
        bus.rd_addr = ra;
        tick();
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
    endtask

    // Count edges until busy drops (bounded) and compare with the required count.
    task automatic wait_ready(input string name, input int exp_edges);
        int edges;
        edges = 0;
        while (edges < 100) begin
            tick();
            edges++;
            if (bus.busy === 1'b0) break;
        end
        check(name, 32'(edges), 32'(exp_edges));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        tick();

        // Init sweep: 2 reset edges, then exactly 32 busy edges.
        rst_n = 1'b0;
        tick();
        tick();
        check("reset_busy", 32'(bus.busy), 32'd1);
        check("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("reset_rd_data", bus.rd_data, 32'd0);
        check("reset_acc_drop", 32'(bus.acc_drop), 32'd0);
        rst_n = 1'b1;
        wait_ready("busy_edges_init", 32);
        check("acc_drop_clean", 32'(bus.acc_drop), 32'd0);
        for (int i = 0; i < 32; i++) rd(5'(i), 32'(i));
        tick();

        // Byte-enabled write, forwarding, independent ports, empty enable.
        wr(5'd7, 32'hAABBCCDD, 4'b0101);
        rd(5'd7, 32'h00BB00DD);
        wr_rd(5'd3, 32'h12345678, 4'b1111, 5'd3, 32'h12345678);
        rd(5'd3, 32'h12345678);
        wr_rd(5'd9, 32'hFFFFFFFF, 4'b1000, 5'd9, 32'hFF000009);
        wr_rd(5'd10, 32'h00000055, 4'b1111, 5'd11, 32'd11);
        rd(5'd10, 32'h00000055);
        wr(5'd12, 32'hFFFFFFFF, 4'b0000);
        rd(5'd12, 32'd12);

        // Idle cycles: no valid, data holds the last read.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_rd_valid", 32'(bus.rd_valid), 32'd0);
            check("idle_rd_data_hold", bus.rd_data, 32'd12);
        end
        rd(5'd1, 32'd1);
        check("b2b_valid_1", 32'(bus.rd_valid), 32'd1);
        rd(5'd2, 32'd2);
        check("b2b_valid_2", 32'(bus.rd_valid), 32'd1);
        rd(5'd3, 32'h12345678);
        check("b2b_valid_3", 32'(bus.rd_valid), 32'd1);
        tick();
        check("b2b_valid_end", 32'(bus.rd_valid), 32'd0);

        // Dropped access at edge 10 of the sweep.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (9) tick();
        wr(5'd5, 32'hDEADBEEF, 4'b1111);
        check("acc_drop_set", 32'(bus.acc_drop), 32'd1);
        check("busy_during_drop", 32'(bus.busy), 32'd1);
        wait_ready("busy_edges_after_drop", 22);
        rd(5'd5, 32'd5);
        rd(5'd3, 32'd3);
        rd(5'd7, 32'd7);
        tick();
        check("acc_drop_sticky", 32'(bus.acc_drop), 32'd1);

        // Reset mid-sweep at edge 12 restarts the full sweep.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (11) tick();
        rst_n = 1'b0;
        tick();
        check("midreset_acc_drop_clear", 32'(bus.acc_drop), 32'd0);
        check("midreset_rd_data", bus.rd_data, 32'd0);
        rst_n = 1'b1;
        wait_ready("busy_edges_midreset", 32);
        for (int i = 0; i < 32; i++) rd(5'(i), 32'(i));
        tick();
        tick();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
